// File: rtl/udma_jtag_tx_arb.sv
// Round-robin burst arbiter that merges NB_CH TX streams into the JTAG FIFO TX port.
// Optional macro JTAG_TX_ARB_PRIO_EN: channel 0 wins every arbitration it takes part in.
module udma_jtag_tx_arb #(
    parameter int NB_CH       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_WIDTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NB_CH-1:0][DATA_WIDTH-1:0]    req_data_i,
    input  logic [NB_CH-1:0]                    req_valid_i,
    output logic [NB_CH-1:0]                    req_ready_o,
    input  logic [BURST_WIDTH-1:0]              burst_len_i,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [NB_CH-1:0]                    grant_o,
    output logic [$clog2(NB_CH)-1:0]            grant_id_o,
    output logic                                busy_o
);

    localparam int IDW = $clog2(NB_CH);
    localparam int IW  = IDW + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 state;
    logic [NB_CH-1:0]       r_grant;
    logic [IDW-1:0]         r_gid;
    logic [IDW-1:0]         r_last;
    logic [BURST_WIDTH-1:0] r_len;
    logic [BURST_WIDTH-1:0] r_cnt;

    logic                   pick_hit;
    logic [IDW-1:0]         pick_id;
    logic [IW-1:0]          rr_sum;
    logic [IDW-1:0]         rr_idx;
    logic                   last_word;

    // Pick the first valid channel after r_last; scan downward so the nearest one wins.
    always_comb begin
        pick_hit = 1'b0;
        pick_id  = '0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int i = NB_CH; i >= 1; i--) begin
            rr_sum = IW'(r_last) + IW'(i);
            rr_idx = (rr_sum >= IW'(NB_CH)) ? IDW'(rr_sum - IW'(NB_CH))
                                            : IDW'(rr_sum);
            if (req_valid_i[rr_idx]) begin
                pick_hit = 1'b1;
                pick_id  = rr_idx;
            end
        end
`ifdef JTAG_TX_ARB_PRIO_EN
        if (req_valid_i[0]) begin
            pick_id = '0;
        end
`else
`endif
    end

    assign last_word = (r_cnt == (r_len - BURST_WIDTH'(1)));

    // Grant FSM: arbitrate in idle, hold the grant for the latched burst length.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            r_grant <= '0;
            r_gid   <= '0;
            r_last  <= IDW'(NB_CH - 1);
            r_len   <= BURST_WIDTH'(1);
            r_cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_hit) begin
                        state   <= ST_GRANT;
                        r_grant <= NB_CH'(1) << pick_id;
                        r_gid   <= pick_id;
                        r_len   <= (burst_len_i == '0) ? BURST_WIDTH'(1)
                                                       : burst_len_i;
                        r_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!req_valid_i[r_gid]) begin
                        state   <= ST_IDLE;
                        r_last  <= r_gid;
                        r_grant <= '0;
                        r_cnt   <= '0;
                    end else if (out_ready_i) begin
                        if (last_word) begin
                            state   <= ST_IDLE;
                            r_last  <= r_gid;
                            r_grant <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + BURST_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Combinational pass-through of the granted channel; everything quiet in idle.
    always_comb begin
        req_ready_o = '0;
        out_data_o  = '0;
        out_valid_o = 1'b0;
        if (state == ST_GRANT) begin
            out_data_o         = req_data_i[r_gid];
            out_valid_o        = req_valid_i[r_gid];
            req_ready_o[r_gid] = out_ready_i;
        end
    end

    assign grant_o    = r_grant;
    assign busy_o     = (state == ST_GRANT);
    assign grant_id_o = busy_o ? r_gid : '0;

endmodule

// File: doc/udma_jtag_tx_arb.md
UDMA_JTAG_TX_ARB -- requirements
Module: udma_jtag_tx_arb

Interface
REQ-001 SHALL have parameter NB_CH, default 4, meaning the number of TX requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the word width, matching the JTAG FIFO TX port.
REQ-003 SHALL have parameter BURST_WIDTH, default 4, meaning the width of the burst-length field and word counter.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port req_data_i, input, NB_CH x DATA_WIDTH: per-requester TX word.
REQ-007 SHALL have port req_valid_i, input, NB_CH: per-requester valid.
REQ-008 SHALL have port req_ready_o, output, NB_CH: per-requester ready.
REQ-009 SHALL have port burst_len_i, input, BURST_WIDTH: words per grant.
REQ-010 SHALL have port out_data_o, output, DATA_WIDTH: word to the JTAG FIFO TX input (data_tx).
REQ-011 SHALL have port out_valid_o, output, 1 bit: valid to the JTAG FIFO.
REQ-012 SHALL have port out_ready_i, input, 1 bit: ready from the JTAG FIFO (data_tx_ready).
REQ-013 SHALL have port grant_o, output, NB_CH: one-hot current grant.
REQ-014 SHALL have port grant_id_o, output, clog2(NB_CH): index of the current grant.
REQ-015 SHALL have port busy_o, output, 1 bit: high in ST_GRANT.

Function
REQ-016 SHALL implement FSM states ST_IDLE and ST_GRANT.
REQ-017 ST_IDLE: SHALL assert no ready, out_valid_o=0, grant_o=0.
REQ-018 ST_IDLE: if any req_valid_i is set, the arbiter SHALL select the first set bit searching upward from (r_last+1) mod NB_CH.
REQ-019 On that selection, the arbiter SHALL register the grant, r_len=max(burst_len_i,1) and r_cnt=0, then enter ST_GRANT next cycle (1-cycle arbitration latency).
REQ-020 ST_GRANT: out_data_o=req_data_i[g], out_valid_o=req_valid_i[g], req_ready_o[g]=out_ready_i, other readies 0; combinational pass-through, no added latency.
REQ-021 Handshake is out_valid_o & out_ready_i; each handshake SHALL increment r_cnt (BURST_WIDTH bits, no wrap possible since r_len<=2^BURST_WIDTH-1).
REQ-022 A handshake with r_cnt==r_len-1 SHALL return the FSM to ST_IDLE and set r_last=g.
REQ-023 Early release: req_valid_i[g]==0 in ST_GRANT SHALL return the FSM to ST_IDLE next cycle with r_last=g; no word is transferred in that cycle.
REQ-024 burst_len_i changes during ST_GRANT SHALL have no effect on the burst in progress.
REQ-025 The arbiter SHALL NOT move to another requester within a burst; a valid on other channels waits.
REQ-026 A requester SHALL never be granted twice in a row while another requester is valid at the arbitration cycle (round-robin fairness).
REQ-027 Back-to-back bursts SHALL be separated by exactly one ST_IDLE cycle.

Reset
REQ-028 rst_i SHALL take effect immediately, independent of clk_i: state=ST_IDLE, r_cnt=0, r_len=1, grant=0, r_last=NB_CH-1 (channel 0 wins first).
REQ-029 Outputs under reset SHALL be: req_ready_o=0, out_valid_o=0, out_data_o=0, grant_o=0, grant_id_o=0, busy_o=0.
REQ-030 Reset mid-burst SHALL abort the burst; the word in flight is dropped and the next grant follows REQ-028 ordering.

Configuration
REQ-031 With macro JTAG_TX_ARB_PRIO_EN defined, channel 0 SHALL win every arbitration cycle in which req_valid_i[0]=1, overriding round-robin; r_last SHALL still update per REQ-022/023.
REQ-032 Without JTAG_TX_ARB_PRIO_EN, arbitration SHALL be pure round-robin per REQ-018.

Verification
REQ-033 Reset release with all four requesters valid, burst_len_i=2, out_ready_i=1 -> grant sequence 0,1,2,3,0, two words each, one idle cycle between bursts.
REQ-034 Only ch2 valid, burst_len_i=0 -> single-word bursts on ch2 only, one idle cycle each, grant_id_o=2.
REQ-035 ch1 granted with burst_len_i=4, out_ready_i low 3 cycles mid-burst -> ready held, r_cnt frozen, exactly 4 words delivered in order, no other grant.
REQ-036 ch3 granted with burst_len_i=8 and valid dropping after 3 words -> FSM in ST_IDLE next cycle, next grant goes to ch0 if valid.
REQ-037 rst_i asserted asynchronously mid-burst -> all outputs 0 in the same cycle; first grant after release goes to ch0.
REQ-038 With JTAG_TX_ARB_PRIO_EN, ch0 and ch1 continuously valid with burst_len_i=1 -> ch0 granted every arbitration and ch1 never granted; without the macro, grants alternate 0,1.
